// File: rtl/imuldiv_muldiv_arb2_pkg.sv
// Shared constants for the two-requester mul/div arbiter: MulDivReq function
// encodings, requester-ID type and the default outstanding-tag depth.
package imuldiv_muldiv_arb2_pkg;

  localparam logic [2:0] MULDIVREQ_MSG_FUNC_MUL  = 3'd0;
  localparam logic [2:0] MULDIVREQ_MSG_FUNC_DIV  = 3'd1;
  localparam logic [2:0] MULDIVREQ_MSG_FUNC_DIVU = 3'd2;
  localparam logic [2:0] MULDIVREQ_MSG_FUNC_REM  = 3'd3;
  localparam logic [2:0] MULDIVREQ_MSG_FUNC_REMU = 3'd4;

  localparam int ARB_ID_W              = 1;
  localparam int ARB_TAG_DEPTH_DEFAULT = 4;

  typedef enum logic [ARB_ID_W-1:0] {
    ARB_ID_0 = 1'b0,
    ARB_ID_1 = 1'b1
  } arb_id_e;

endpackage

// File: rtl/imuldiv_muldiv_arb2_tag_queue.sv
// 1-bit-wide FIFO remembering which requester owns each outstanding request,
// in the order the requests were sent downstream.
module imuldiv_arb_tag_queue #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enq_val,
  input  logic enq_data,
  input  logic deq_val,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int COUNT_W = PTR_W + 1;

  logic [PTR_W-1:0]   head_ptr_q, head_ptr_d;
  logic [PTR_W-1:0]   tail_ptr_q, tail_ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0]   mem_q, mem_d;
  logic               do_enq, do_deq;

  always_comb begin
    full   = (count_q == COUNT_W'(DEPTH));
    empty  = (count_q == '0);
    head   = mem_q[head_ptr_q];
    // A push into a full queue is refused even if a pop frees a slot this cycle.
    do_enq = enq_val & ~full;
    do_deq = deq_val & ~empty;

    mem_d = mem_q;
    if (do_enq) mem_d[tail_ptr_q] = enq_data;

    // Pointers wrap naturally because DEPTH is a power of two.
    head_ptr_d = head_ptr_q + PTR_W'(do_deq);
    tail_ptr_d = tail_ptr_q + PTR_W'(do_enq);

    count_d = count_q;
    case ({do_enq, do_deq})
      2'b10:   count_d = count_q + COUNT_W'(1);
      2'b01:   count_d = count_q - COUNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_ptr_q <= '0;
      tail_ptr_q <= '0;
      count_q    <= '0;
    end else begin
      head_ptr_q <= head_ptr_d;
      tail_ptr_q <= tail_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/imuldiv_muldiv_arb2.sv
// Round-robin arbiter sharing one mul/div unit between two requesters; a tag
// queue steers in-order responses back to the requester that issued them.
module imuldiv_muldiv_arb2
  import imuldiv_muldiv_arb2_pkg::*;
#(
  parameter int TAG_DEPTH = ARB_TAG_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [2:0]  req0_msg_fn,
  input  logic [31:0] req0_msg_a,
  input  logic [31:0] req0_msg_b,
  input  logic        req0_val,
  output logic        req0_rdy,
  output logic [31:0] resp0_msg_result,
  output logic        resp0_val,
  input  logic        resp0_rdy,

  input  logic [2:0]  req1_msg_fn,
  input  logic [31:0] req1_msg_a,
  input  logic [31:0] req1_msg_b,
  input  logic        req1_val,
  output logic        req1_rdy,
  output logic [31:0] resp1_msg_result,
  output logic        resp1_val,
  input  logic        resp1_rdy,

  output logic [2:0]  muldivreq_msg_fn,
  output logic [31:0] muldivreq_msg_a,
  output logic [31:0] muldivreq_msg_b,
  output logic        muldivreq_val,
  input  logic        muldivreq_rdy,

  input  logic [31:0] muldivresp_msg_result,
  input  logic        muldivresp_val,
  output logic        muldivresp_rdy
);

  arb_id_e prio_q, prio_d, grant;
  logic    rst_dly_q, rst_dly_d;
  logic    out_en;
  logic    tag_full, tag_empty, head_tag;
  logic    head_rdy, req_xfer, resp_xfer;

  always_comb begin
    // Handshakes stay quiet while reset is high and for one cycle after it.
    out_en    = ~reset & ~rst_dly_q;
    rst_dly_d = reset;

    grant = prio_q;
    if (req0_val && !req1_val)      grant = ARB_ID_0;
    else if (req1_val && !req0_val) grant = ARB_ID_1;

    muldivreq_val = (req0_val | req1_val) & ~tag_full & out_en;
    req0_rdy      = (grant == ARB_ID_0) & muldivreq_rdy & ~tag_full & out_en;
    req1_rdy      = (grant == ARB_ID_1) & muldivreq_rdy & ~tag_full & out_en;

    if (grant == ARB_ID_1) begin
      muldivreq_msg_fn = req1_msg_fn;
      muldivreq_msg_a  = req1_msg_a;
      muldivreq_msg_b  = req1_msg_b;
    end else begin
      muldivreq_msg_fn = req0_msg_fn;
      muldivreq_msg_a  = req0_msg_a;
      muldivreq_msg_b  = req0_msg_b;
    end

    // A response with no outstanding tag is a protocol error and is never accepted.
    head_rdy       = head_tag ? resp1_rdy : resp0_rdy;
    muldivresp_rdy = ~tag_empty & head_rdy & out_en;
    resp0_val      = muldivresp_val & ~tag_empty & ~head_tag & out_en;
    resp1_val      = muldivresp_val & ~tag_empty & head_tag & out_en;

    req_xfer  = muldivreq_val & muldivreq_rdy;
    resp_xfer = muldivresp_val & muldivresp_rdy;

    prio_d = prio_q;
    if (req_xfer) prio_d = (grant == ARB_ID_0) ? ARB_ID_1 : ARB_ID_0;
  end

  assign resp0_msg_result = muldivresp_msg_result;
  assign resp1_msg_result = muldivresp_msg_result;

  always_ff @(posedge clk) begin
    rst_dly_q <= rst_dly_d;
    if (reset) prio_q <= ARB_ID_0;
    else       prio_q <= prio_d;
  end

  imuldiv_arb_tag_queue #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_queue (
    .clk      (clk),
    .reset    (reset),
    .enq_val  (req_xfer),
    .enq_data (grant),
    .deq_val  (resp_xfer),
    .full     (tag_full),
    .empty    (tag_empty),
    .head     (head_tag)
  );

endmodule

// File: tb/tb_imuldiv_muldiv_arb2.sv
// Directed scoreboard bench for the two-requester mul/div arbiter; the bench
// also plays the shared mul/div unit with an in-order response queue.
module tb_imuldiv_muldiv_arb2;
  import imuldiv_muldiv_arb2_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req0_msg_fn, req1_msg_fn, muldivreq_msg_fn;
  logic [31:0] req0_msg_a, req0_msg_b, req1_msg_a, req1_msg_b;
  logic [31:0] muldivreq_msg_a, muldivreq_msg_b;
  logic        req0_val, req0_rdy, req1_val, req1_rdy;
  logic [31:0] resp0_msg_result, resp1_msg_result, muldivresp_msg_result;
  logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;
  logic        muldivreq_val, muldivreq_rdy, muldivresp_val, muldivresp_rdy;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp0[$];
  logic [31:0] exp1[$];
  logic [31:0] unit_q[$];
  logic        unit_en, spurious;

  always #5 clk = ~clk;

  imuldiv_muldiv_arb2 #(.TAG_DEPTH(4)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .req0_msg_fn           (req0_msg_fn),
    .req0_msg_a            (req0_msg_a),
    .req0_msg_b            (req0_msg_b),
    .req0_val              (req0_val),
    .req0_rdy              (req0_rdy),
    .resp0_msg_result      (resp0_msg_result),
    .resp0_val             (resp0_val),
    .resp0_rdy             (resp0_rdy),
    .req1_msg_fn           (req1_msg_fn),
    .req1_msg_a            (req1_msg_a),
    .req1_msg_b            (req1_msg_b),
    .req1_val              (req1_val),
    .req1_rdy              (req1_rdy),
    .resp1_msg_result      (resp1_msg_result),
    .resp1_val             (resp1_val),
    .resp1_rdy             (resp1_rdy),
    .muldivreq_msg_fn      (muldivreq_msg_fn),
    .muldivreq_msg_a       (muldivreq_msg_a),
    .muldivreq_msg_b       (muldivreq_msg_b),
    .muldivreq_val         (muldivreq_val),
    .muldivreq_rdy         (muldivreq_rdy),
    .muldivresp_msg_result (muldivresp_msg_result),
    .muldivresp_val        (muldivresp_val),
    .muldivresp_rdy        (muldivresp_rdy)
  );

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] unit_calc(input logic [2:0] fn, input logic [31:0] a,
                                            input logic [31:0] b);
    if (fn == MULDIVREQ_MSG_FUNC_MUL) return a * b;
    if (fn == MULDIVREQ_MSG_FUNC_DIV && b != 0) return $signed(a) / $signed(b);
    return 32'h0;
  endfunction

  // Shared unit stand-in: accepts every granted request, answers in order.
  initial begin
    muldivresp_val        = 1'b0;
    muldivresp_msg_result = 32'h0;
    forever begin
      @(posedge clk);
      if (muldivresp_val && muldivresp_rdy && unit_q.size() > 0) void'(unit_q.pop_front());
      if (muldivreq_val && muldivreq_rdy)
        unit_q.push_back(unit_calc(muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b));
      if (reset) unit_q.delete();
      #2;
      muldivresp_val        = spurious || (unit_en && unit_q.size() > 0);
      muldivresp_msg_result = (unit_q.size() > 0) ? unit_q[0] : 32'hDEADBEEF;
    end
  end

  // Response monitor: every accepted response must match the next expected one.
  initial begin
    forever begin
      @(negedge clk);
      if (resp0_val && resp0_rdy) begin
        if (exp0.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp0_unexpected: got %0h, expected no response", resp0_msg_result);
        end else chk32("resp0_result", resp0_msg_result, exp0.pop_front());
      end
      if (resp1_val && resp1_rdy) begin
        if (exp1.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp1_unexpected: got %0h, expected no response", resp1_msg_result);
        end else chk32("resp1_result", resp1_msg_result, exp1.pop_front());
      end
    end
  end

  task automatic idle();
    req0_val = 1'b0;
    req1_val = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset    = 1'b1;
    req0_val = 1'b1;
    req1_val = 1'b1;
    exp0.delete();
    exp1.delete();
    @(negedge clk);
    chk1("rst_req0_rdy", req0_rdy, 1'b0);
    chk1("rst_req1_rdy", req1_rdy, 1'b0);
    chk1("rst_muldivreq_val", muldivreq_val, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
    @(negedge clk);
    chk1("post_rst_req0_rdy", req0_rdy, 1'b0);
    chk1("post_rst_req1_rdy", req1_rdy, 1'b0);
    chk1("post_rst_resp0_val", resp0_val, 1'b0);
    chk1("post_rst_resp1_val", resp1_val, 1'b0);
    chk1("post_rst_muldivreq_val", muldivreq_val, 1'b0);
    chk1("post_rst_muldivresp_rdy", muldivresp_rdy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int port, input logic [2:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    logic rdy;
    rdy = 1'b0;
    if (port == 0) begin
      req0_msg_fn = fn; req0_msg_a = a; req0_msg_b = b; req0_val = 1'b1;
    end else begin
      req1_msg_fn = fn; req1_msg_a = a; req1_msg_b = b; req1_val = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rdy = (port == 0) ? req0_rdy : req1_rdy;
      if (rdy) break;
      @(posedge clk);
      #1;
    end
    chk1((port == 0) ? "issue_req0_rdy" : "issue_req1_rdy", rdy, 1'b1);
    chk32("issue_msg_a", muldivreq_msg_a, a);
    chk32("issue_msg_b", muldivreq_msg_b, b);
    if (rdy) begin
      if (port == 0) exp0.push_back(exp);
      else           exp1.push_back(exp);
    end
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      if (exp0.size() == 0 && exp1.size() == 0 && unit_q.size() == 0) break;
      @(posedge clk);
    end
    chk32("drain_exp0_left", exp0.size(), 32'd0);
    chk32("drain_exp1_left", exp1.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req0_msg_fn = MULDIVREQ_MSG_FUNC_MUL; req0_msg_a = 32'd1; req0_msg_b = 32'd1;
    req1_msg_fn = MULDIVREQ_MSG_FUNC_MUL; req1_msg_a = 32'd1; req1_msg_b = 32'd1;
    idle();
    resp0_rdy = 1'b1; resp1_rdy = 1'b1; muldivreq_rdy = 1'b1;
    unit_en = 1'b1; spurious = 1'b0;
    do_reset();

    // Single requester: MUL 3*7 then DIV -20/3.
    issue(0, MULDIVREQ_MSG_FUNC_MUL, 32'd3, 32'd7, 32'd21);
    issue(0, MULDIVREQ_MSG_FUNC_DIV, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFA);
    wait_drain();

    // Contention: both valid for 4 cycles, grants alternate starting with 0.
    do_reset();
    req0_msg_fn = MULDIVREQ_MSG_FUNC_MUL; req0_msg_a = 32'd2; req0_msg_b = 32'd2;
    req1_msg_fn = MULDIVREQ_MSG_FUNC_MUL; req1_msg_a = 32'd5; req1_msg_b = 32'd5;
    req0_val = 1'b1; req1_val = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1("cont_req0_rdy", req0_rdy, (k % 2) == 0);
      chk1("cont_req1_rdy", req1_rdy, (k % 2) == 1);
      chk32("cont_msg_a", muldivreq_msg_a, ((k % 2) == 0) ? 32'd2 : 32'd5);
      if ((k % 2) == 0) exp0.push_back(32'd4);
      else              exp1.push_back(32'd25);
      @(posedge clk);
      #1;
    end
    idle();
    wait_drain();

    // Full queue: responses to requester 0 held back, fifth request must stall.
    do_reset();
    resp0_rdy = 1'b0;
    req0_msg_fn = MULDIVREQ_MSG_FUNC_MUL; req0_msg_b = 32'd1; req0_val = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      req0_msg_a = 32'(i);
      @(negedge clk);
      chk1("fill_req0_rdy", req0_rdy, 1'b1);
      exp0.push_back(32'(i));
      @(posedge clk);
      #1;
    end
    req0_msg_a = 32'd5;
    @(negedge clk);
    chk1("full_req0_rdy", req0_rdy, 1'b0);
    chk1("full_muldivreq_val", muldivreq_val, 1'b0);
    chk1("full_muldivresp_rdy", muldivresp_rdy, 1'b0);
    @(posedge clk);
    #1;
    resp0_rdy = 1'b1;
    @(negedge clk);
    chk1("release_req0_rdy", req0_rdy, 1'b0);
    chk1("release_muldivresp_rdy", muldivresp_rdy, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk1("resume_req0_rdy", req0_rdy, 1'b1);
    exp0.push_back(32'd5);
    @(posedge clk);
    #1;
    idle();
    wait_drain();

    // Response backpressure: head tag belongs to requester 1, which is not ready.
    do_reset();
    unit_en = 1'b0;
    issue(1, MULDIVREQ_MSG_FUNC_MUL, 32'd6, 32'd7, 32'd42);
    issue(0, MULDIVREQ_MSG_FUNC_MUL, 32'd8, 32'd9, 32'd72);
    resp1_rdy = 1'b0;
    unit_en   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("bp_muldivresp_rdy", muldivresp_rdy, 1'b0);
      chk1("bp_resp0_val", resp0_val, 1'b0);
      chk1("bp_resp1_val", resp1_val, 1'b1);
      @(posedge clk);
      #1;
    end
    resp1_rdy = 1'b1;
    wait_drain();

    // Mid-operation reset with two tags outstanding and priority moved to 1.
    unit_en = 1'b0;
    issue(0, MULDIVREQ_MSG_FUNC_MUL, 32'd1, 32'd2, 32'd2);
    issue(0, MULDIVREQ_MSG_FUNC_MUL, 32'd3, 32'd4, 32'd12);
    do_reset();
    req0_msg_fn = MULDIVREQ_MSG_FUNC_MUL; req0_msg_a = 32'd2; req0_msg_b = 32'd3;
    req1_msg_fn = MULDIVREQ_MSG_FUNC_MUL; req1_msg_a = 32'd4; req1_msg_b = 32'd5;
    req0_val = 1'b1; req1_val = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk1("mrst_req0_rdy", req0_rdy, k < 4 && (k % 2) == 0);
      chk1("mrst_req1_rdy", req1_rdy, k < 4 && (k % 2) == 1);
      if (k < 4) begin
        if ((k % 2) == 0) exp0.push_back(32'd6);
        else              exp1.push_back(32'd20);
      end
      @(posedge clk);
      #1;
    end
    idle();
    unit_en = 1'b1;
    wait_drain();

    // Spurious response on an empty queue is ignored and leaves state intact.
    spurious = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk1("spur_muldivresp_rdy", muldivresp_rdy, 1'b0);
      chk1("spur_resp0_val", resp0_val, 1'b0);
      chk1("spur_resp1_val", resp1_val, 1'b0);
      @(posedge clk);
      #1;
    end
    spurious = 1'b0;
    issue(1, MULDIVREQ_MSG_FUNC_MUL, 32'd7, 32'd3, 32'd21);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
